// File: rtl/video_timing_gen.sv
// Raster timing generator feeding pixel_generator and the TMDS encoder.
// Optional frame counter output enabled by defining VTG_FRAME_COUNT_EN.
//
// state | meaning
// LOAD  | latch timing ports into shadow registers, outputs blanked
// CHECK | validate shadow timing; RUN if sane, else flag o_err and reload
// RUN   | scan hcount/vcount with shadow timing until the last pixel of the frame

module video_timing_gen #(
  parameter int HW  = 12,
  parameter int VW  = 12,
  parameter int BPP = 12
) (
  input  logic           i_pixclk,
  input  logic           i_reset,
  input  logic [HW-1:0]  i_hm_width,
  input  logic [HW-1:0]  i_hm_porch,
  input  logic [HW-1:0]  i_hm_synch,
  input  logic [HW-1:0]  i_hm_raw,
  input  logic [VW-1:0]  i_vm_height,
  input  logic [VW-1:0]  i_vm_porch,
  input  logic [VW-1:0]  i_vm_synch,
  input  logic [VW-1:0]  i_vm_raw,
  input  logic [BPP-1:0] i_pixel,
  output logic           o_rd,
  output logic           o_newline,
  output logic           o_newframe,
  output logic           o_de,
  output logic           o_hsync,
  output logic           o_vsync,
  output logic [BPP-1:0] o_pixel,
`ifdef VTG_FRAME_COUNT_EN
  output logic [15:0]    o_frame_count,
`endif
  output logic           o_err
);

  typedef enum logic [1:0] {S_LOAD, S_CHECK, S_RUN} state_t;

  localparam logic [HW-1:0] H_ONE = 1;
  localparam logic [VW-1:0] V_ONE = 1;

  state_t        state_q, state_d;
  logic [HW-1:0] hw_q, hw_d, hp_q, hp_d, hs_q, hs_d, hr_q, hr_d;
  logic [VW-1:0] vh_q, vh_d, vp_q, vp_d, vs_q, vs_d, vr_q, vr_d;
  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d;
  logic          err_q, err_d;
  logic          rd_q, rd_d, newline_q, newline_d, newframe_q, newframe_d;
  logic          hsync_pos_q, hsync_pos_d, vsync_pos_q, vsync_pos_d;
  logic          de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic          cfg_ok, run_d;

  always_comb begin
    cfg_ok = (hw_q != '0) && (hw_q <= hp_q) && (hp_q < hs_q) && (hs_q < hr_q) &&
             (vh_q != '0) && (vh_q <= vp_q) && (vp_q < vs_q) && (vs_q < vr_q);

    state_d  = state_q;
    hw_d     = hw_q;
    hp_d     = hp_q;
    hs_d     = hs_q;
    hr_d     = hr_q;
    vh_d     = vh_q;
    vp_d     = vp_q;
    vs_d     = vs_q;
    vr_d     = vr_q;
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    err_d    = err_q;

    case (state_q)
      S_LOAD: begin
        hw_d     = i_hm_width;
        hp_d     = i_hm_porch;
        hs_d     = i_hm_synch;
        hr_d     = i_hm_raw;
        vh_d     = i_vm_height;
        vp_d     = i_vm_porch;
        vs_d     = i_vm_synch;
        vr_d     = i_vm_raw;
        hcount_d = '0;
        vcount_d = '0;
        state_d  = S_CHECK;
      end
      S_CHECK: begin
        hcount_d = '0;
        vcount_d = '0;
        if (cfg_ok) begin
          err_d   = 1'b0;
          state_d = S_RUN;
        end else begin
          err_d   = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_RUN: begin
        if (hcount_q == hr_q - H_ONE) begin
          hcount_d = '0;
          if (vcount_q == vr_q - V_ONE) begin
            vcount_d = '0;
            state_d  = S_LOAD;
          end else begin
            vcount_d = vcount_q + V_ONE;
          end
        end else begin
          hcount_d = hcount_q + H_ONE;
        end
      end
      default: state_d = S_LOAD;
    endcase

    // Strobes are computed from the next position so the registered
    // outputs line up with the position held in hcount_q/vcount_q.
    run_d       = (state_d == S_RUN);
    rd_d        = run_d && (hcount_d < hw_q) && (vcount_d < vh_q);
    newline_d   = run_d && (hcount_d == hr_q - H_ONE);
    newframe_d  = newline_d && (vcount_d == vr_q - V_ONE);
    hsync_pos_d = !(run_d && (hcount_d >= hp_q) && (hcount_d < hs_q));
    vsync_pos_d = !(run_d && (vcount_d >= vp_q) && (vcount_d < vs_q));

    // One-cycle delay matches the registered pixel from pixel_generator.
    de_d    = rd_q;
    hsync_d = hsync_pos_q;
    vsync_d = vsync_pos_q;
  end

  always_ff @(posedge i_pixclk) begin
    if (i_reset) begin
      state_q     <= S_LOAD;
      hw_q        <= '0;
      hp_q        <= '0;
      hs_q        <= '0;
      hr_q        <= '0;
      vh_q        <= '0;
      vp_q        <= '0;
      vs_q        <= '0;
      vr_q        <= '0;
      hcount_q    <= '0;
      vcount_q    <= '0;
      err_q       <= 1'b0;
      rd_q        <= 1'b0;
      newline_q   <= 1'b0;
      newframe_q  <= 1'b0;
      hsync_pos_q <= 1'b1;
      vsync_pos_q <= 1'b1;
      de_q        <= 1'b0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      hw_q        <= hw_d;
      hp_q        <= hp_d;
      hs_q        <= hs_d;
      hr_q        <= hr_d;
      vh_q        <= vh_d;
      vp_q        <= vp_d;
      vs_q        <= vs_d;
      vr_q        <= vr_d;
      hcount_q    <= hcount_d;
      vcount_q    <= vcount_d;
      err_q       <= err_d;
      rd_q        <= rd_d;
      newline_q   <= newline_d;
      newframe_q  <= newframe_d;
      hsync_pos_q <= hsync_pos_d;
      vsync_pos_q <= vsync_pos_d;
      de_q        <= de_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
    end
  end

`ifdef VTG_FRAME_COUNT_EN
  logic [15:0] frame_count_q, frame_count_d;

  always_comb frame_count_d = frame_count_q + {15'd0, newframe_q};

  always_ff @(posedge i_pixclk) begin
    if (i_reset) frame_count_q <= '0;
    else         frame_count_q <= frame_count_d;
  end

  assign o_frame_count = frame_count_q;
`endif

  assign o_rd       = rd_q;
  assign o_newline  = newline_q;
  assign o_newframe = newframe_q;
  assign o_de       = de_q;
  assign o_hsync    = hsync_q;
  assign o_vsync    = vsync_q;
  assign o_pixel    = de_q ? i_pixel : '0;
  assign o_err      = err_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen with h(4,5,6,8) v(3,4,5,6) timing.
module tb_video_timing_gen;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [11:0] i_hm_width, i_hm_porch, i_hm_synch, i_hm_raw;
  logic [11:0] i_vm_height, i_vm_porch, i_vm_synch, i_vm_raw;
  logic [11:0] i_pixel;
  logic        o_rd, o_newline, o_newframe, o_de, o_hsync, o_vsync, o_err;
  logic [11:0] o_pixel;
`ifdef VTG_FRAME_COUNT_EN
  logic [15:0] frame_count;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  video_timing_gen #(.HW(12), .VW(12), .BPP(12)) dut (
    .i_pixclk    (clk),
    .i_reset     (i_reset),
    .i_hm_width  (i_hm_width),
    .i_hm_porch  (i_hm_porch),
    .i_hm_synch  (i_hm_synch),
    .i_hm_raw    (i_hm_raw),
    .i_vm_height (i_vm_height),
    .i_vm_porch  (i_vm_porch),
    .i_vm_synch  (i_vm_synch),
    .i_vm_raw    (i_vm_raw),
    .i_pixel     (i_pixel),
    .o_rd        (o_rd),
    .o_newline   (o_newline),
    .o_newframe  (o_newframe),
    .o_de        (o_de),
    .o_hsync     (o_hsync),
    .o_vsync     (o_vsync),
    .o_pixel     (o_pixel),
`ifdef VTG_FRAME_COUNT_EN
    .o_frame_count (frame_count),
`endif
    .o_err       (o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; new i_pixel is driven and outputs are sampled 2ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    i_pixel = cyc[11:0];
    #1;
  endtask

  // Checks one 50-cycle frame period (48 active positions + LOAD + CHECK),
  // starting at position (0,0). Optionally rewrites i_hm_width at cycle chg_at.
  task automatic check_frame(input int w, input int chg_at, input int new_w);
    logic p_rd, p_hs, p_vs;
    logic e_rd, e_nl, e_nf, e_hs, e_vs, run;
    int h, v;
    logic [11:0] e_pix;
    p_rd = 1'b0;
    p_hs = 1'b1;
    p_vs = 1'b1;
    for (int c = 0; c < 50; c++) begin
      run  = (c < 48);
      h    = c % 8;
      v    = c / 8;
      e_rd = run && (h < w) && (v < 3);
      e_nl = run && (h == 7);
      e_nf = e_nl && (v == 5);
      e_hs = !(run && (h == 5));
      e_vs = !(run && (v == 4));
      e_pix = p_rd ? cyc[11:0] : 12'd0;
      chk("rd", o_rd, e_rd);
      chk("newline", o_newline, e_nl);
      chk("newframe", o_newframe, e_nf);
      chk("de", o_de, p_rd);
      chk("hsync", o_hsync, p_hs);
      chk("vsync", o_vsync, p_vs);
      chk("pixel", o_pixel, e_pix);
      chk("err_run", o_err, 1'b0);
      if (c == chg_at) i_hm_width = new_w[11:0];
      p_rd = e_rd;
      p_hs = e_hs;
      p_vs = e_vs;
      tick();
    end
  endtask

  initial begin
    i_reset     = 1'b1;
    i_hm_width  = 12'd4;
    i_hm_porch  = 12'd5;
    i_hm_synch  = 12'd6;
    i_hm_raw    = 12'd8;
    i_vm_height = 12'd3;
    i_vm_porch  = 12'd4;
    i_vm_synch  = 12'd5;
    i_vm_raw    = 12'd6;
    i_pixel     = 12'd0;
    repeat (3) tick();

    chk("rst_rd", o_rd, 1'b0);
    chk("rst_newline", o_newline, 1'b0);
    chk("rst_newframe", o_newframe, 1'b0);
    chk("rst_de", o_de, 1'b0);
    chk("rst_hsync", o_hsync, 1'b1);
    chk("rst_vsync", o_vsync, 1'b1);
    chk("rst_pixel", o_pixel, 12'd0);
    chk("rst_err", o_err, 1'b0);
`ifdef VTG_FRAME_COUNT_EN
    chk("rst_fcount", frame_count, 16'd0);
`endif

    i_reset = 1'b0;
    tick();
    chk("load_blank_rd", o_rd, 1'b0);
    tick();
    check_frame(4, -1, 4);
    check_frame(4, -1, 4);
    check_frame(4, -1, 4);
`ifdef VTG_FRAME_COUNT_EN
    chk("fcount_3", frame_count, 16'd3);
`endif

    // Run to hcount=3, vcount=1 and reset there.
    repeat (11) tick();
    chk("pre_reset_rd", o_rd, 1'b1);
    i_reset = 1'b1;
    tick();
    chk("mid_rst_rd", o_rd, 1'b0);
    chk("mid_rst_de", o_de, 1'b0);
    chk("mid_rst_hsync", o_hsync, 1'b1);
    chk("mid_rst_vsync", o_vsync, 1'b1);
    chk("mid_rst_newline", o_newline, 1'b0);
`ifdef VTG_FRAME_COUNT_EN
    chk("mid_rst_fcount", frame_count, 16'd0);
`endif
    i_reset = 1'b0;
    tick();
    tick();

    check_frame(4, 10, 2);
    check_frame(2, -1, 2);
    check_frame(2, 0, 0);
`ifdef VTG_FRAME_COUNT_EN
    chk("fcount_after_rst", frame_count, 16'd3);
`endif

    for (int i = 0; i < 10; i++) begin
      chk("bad_err", o_err, 1'b1);
      chk("bad_rd", o_rd, 1'b0);
      chk("bad_newline", o_newline, 1'b0);
      tick();
    end

    i_hm_width = 12'd4;
    for (int i = 0; i < 6 && o_err !== 1'b0; i++) tick();
    chk("err_cleared", o_err, 1'b0);
    check_frame(4, -1, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
